bg_tile_fetcher: RTL and testbench

- Producer end of the PPU pixel FIFO; the framebuffer sits at the consumer end and pops pixels.
- During mode 3 it walks the background tile map, reads tile index, low plane and high plane bytes from VRAM, and pushes 8 decoded pixels per tile into the FIFO.
- Applies SCX/SCY scroll with 32-tile wrap.
- Signals when the scanline's tiles have all been fetched.

---
 rtl/bg_tile_fetcher_if.sv | 20 ++
 rtl/bg_tile_fetcher.sv | 159 +++++++++++++++
 tb/tb_bg_tile_fetcher.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bg_tile_fetcher_if.sv
// Bus bundle between the background tile fetcher, VRAM and the pixel FIFO.
// The fetcher is the master: it issues VRAM reads and pushes pixel groups.
interface bg_tile_fetcher_if;
  logic [12:0] vram_addr;
  logic        vram_rd;
  logic [7:0]  vram_rdata;
  logic [4:0]  fifo_count;
  logic        fifo_push_en;
  logic [15:0] fifo_push_colors;

  modport master (
    output vram_addr, vram_rd, fifo_push_en, fifo_push_colors,
    input  vram_rdata, fifo_count
  );

  modport slave (
    input  vram_addr, vram_rd, fifo_push_en, fifo_push_colors,
    output vram_rdata, fifo_count
  );
endinterface

// File: rtl/bg_tile_fetcher.sv
// Background tile fetcher: walks the BG tile map for the current scanline,
// reads tile index / low plane / high plane bytes from VRAM and pushes
// 8 decoded 2-bit pixels per tile into the pixel FIFO.
module bg_tile_fetcher #(
  parameter int FIFO_DEPTH     = 16,
  parameter int TILES_PER_LINE = 21
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dot_en,
  input  logic       start_line,
  input  logic [7:0] ly,
  input  logic [7:0] scx,
  input  logic [7:0] scy,
  input  logic       lcdc_bg_map_sel,
  input  logic       lcdc_tile_data_sel,
  bg_tile_fetcher_if.master bus,
  output logic       line_done
);

  localparam int                CNT_W      = $clog2(TILES_PER_LINE + 1);
  localparam logic [5:0]        PUSH_LIMIT = 6'(FIFO_DEPTH - 8);
  localparam logic [CNT_W-1:0]  LAST_TILE  = CNT_W'(TILES_PER_LINE - 1);

  typedef enum logic [2:0] {
    IDLE, TILE_REQ, TILE_CAP, LO_REQ, LO_CAP, HI_REQ, HI_CAP, PUSH
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       fetch_x_q, fetch_x_d;
  logic [CNT_W-1:0] tile_cnt_q, tile_cnt_d;
  logic [7:0]       tile_idx_q, tile_idx_d;
  logic [7:0]       lo_q, lo_d;
  logic [7:0]       hi_q, hi_d;
  logic [12:0]      addr_q, addr_d;
  logic             done_pend_q, done_pend_d;

  logic [7:0]  yy;
  logic [2:0]  row;
  logic [4:0]  map_col;
  logic [12:0] map_addr;
  logic [12:0] data_addr;
  logic        has_space;
  logic        push_fire;
  logic        req_state;
  logic [15:0] colors;

  // Scroll is sampled live; map column wraps at 32 tiles via 5-bit arithmetic.
  assign yy       = ly + scy;
  assign row      = yy[2:0];
  assign map_col  = scx[7:3] + fetch_x_q;
  assign map_addr = {2'b11, lcdc_bg_map_sel, yy[7:3], map_col};

  // Unsigned mode indexes from 0x0000; signed mode treats the index as
  // two's complement around 0x1000, wrapping inside the 13-bit VRAM space.
  assign data_addr = lcdc_tile_data_sel
                   ? {1'b0, tile_idx_q, row, 1'b0}
                   : 13'h1000 + {tile_idx_q[7], tile_idx_q, 4'b0000} + {9'd0, row, 1'b0};

  assign has_space = ({1'b0, bus.fifo_count} <= PUSH_LIMIT);
  assign req_state = (state_q == TILE_REQ) || (state_q == LO_REQ) || (state_q == HI_REQ);
  assign push_fire = (state_q == PUSH) && dot_en && has_space && !start_line;

  // Leftmost pixel lands in the top bits; colour = {hi bit, lo bit}.
  for (genvar gi = 0; gi < 8; gi++) begin : g_pix
    assign colors[15-2*gi -: 2] = {hi_q[7-gi], lo_q[7-gi]};
  end

  // Output decode: address is driven live in request states, held otherwise.
  always_comb begin
    bus.vram_addr = addr_q;
    case (state_q)
      TILE_REQ: bus.vram_addr = map_addr;
      LO_REQ:   bus.vram_addr = data_addr;
      HI_REQ:   bus.vram_addr = {data_addr[12:1], 1'b1};
      default:  bus.vram_addr = addr_q;
    endcase
    bus.vram_rd          = dot_en && req_state;
    bus.fifo_push_en     = push_fire;
    bus.fifo_push_colors = (state_q == PUSH) ? colors : 16'h0000;
    line_done            = dot_en && done_pend_q && !start_line;
  end

  // Next-state logic: start_line overrides everything; otherwise advance on dot_en.
  always_comb begin
    state_d     = state_q;
    fetch_x_d   = fetch_x_q;
    tile_cnt_d  = tile_cnt_q;
    tile_idx_d  = tile_idx_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    addr_d      = bus.vram_addr;
    done_pend_d = done_pend_q;
    if (start_line) begin
      state_d     = TILE_REQ;
      fetch_x_d   = 5'd0;
      tile_cnt_d  = '0;
      done_pend_d = 1'b0;
    end else if (dot_en) begin
      // A pending line_done is emitted this cycle, so retire it.
      done_pend_d = 1'b0;
      case (state_q)
        IDLE:     state_d = IDLE;
        TILE_REQ: state_d = TILE_CAP;
        TILE_CAP: begin
          tile_idx_d = bus.vram_rdata;
          state_d    = LO_REQ;
        end
        LO_REQ:   state_d = LO_CAP;
        LO_CAP: begin
          lo_d    = bus.vram_rdata;
          state_d = HI_REQ;
        end
        HI_REQ:   state_d = HI_CAP;
        HI_CAP: begin
          hi_d    = bus.vram_rdata;
          state_d = PUSH;
        end
        PUSH: begin
          if (has_space) begin
            fetch_x_d  = fetch_x_q + 5'd1;
            tile_cnt_d = tile_cnt_q + 1'b1;
            if (tile_cnt_q == LAST_TILE) begin
              state_d     = IDLE;
              done_pend_d = 1'b1;
            end else begin
              state_d = TILE_REQ;
            end
          end
        end
        default:  state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers; asynchronous reset abandons any tile in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      fetch_x_q   <= 5'd0;
      tile_cnt_q  <= '0;
      tile_idx_q  <= 8'd0;
      lo_q        <= 8'd0;
      hi_q        <= 8'd0;
      addr_q      <= 13'd0;
      done_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_x_q   <= fetch_x_d;
      tile_cnt_q  <= tile_cnt_d;
      tile_idx_q  <= tile_idx_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      addr_q      <= addr_d;
      done_pend_q <= done_pend_d;
    end
  end

endmodule

// File: tb/tb_bg_tile_fetcher.sv
// Self-checking bench for bg_tile_fetcher: directed scenarios plus randomized
// scanlines compared against a tile-level model of the map/tile-data rules.
module tb_bg_tile_fetcher;

  logic       clk;
  logic       reset;
  logic       dot_en;
  logic       start_line;
  logic [7:0] ly, scx, scy;
  logic       map_sel, data_sel;
  logic       line_done;
  logic [7:0] vram_rdata_r;

  bg_tile_fetcher_if bus ();

  bg_tile_fetcher #(.FIFO_DEPTH(16), .TILES_PER_LINE(21)) dut (
    .clk                (clk),
    .reset              (reset),
    .dot_en             (dot_en),
    .start_line         (start_line),
    .ly                 (ly),
    .scx                (scx),
    .scy                (scy),
    .lcdc_bg_map_sel    (map_sel),
    .lcdc_tile_data_sel (data_sel),
    .bus                (bus),
    .line_done          (line_done)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] vram [0:8191];

  // VRAM model: data appears on the edge after a dot_en read cycle and holds.
  always @(posedge clk) begin
    if (dot_en && bus.vram_rd) vram_rdata_r <= vram[bus.vram_addr];
  end
  assign bus.vram_rdata = vram_rdata_r;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sampled outputs of the most recent step.
  logic        o_rd, o_push, o_done;
  logic [12:0] o_addr;
  logic [15:0] o_col;

  // Observed and expected per-line transaction streams.
  logic [12:0] rd_q[$];
  logic [15:0] col_q[$];
  logic [12:0] exp_addr_q[$];
  logic [15:0] exp_col_q[$];
  int done_cnt, viol;
  bit timeout;

  // One clock: drive inputs, sample outputs mid-cycle, advance past the edge.
  task automatic step(input logic d, input logic s);
    dot_en     = d;
    start_line = s;
    @(negedge clk);
    o_rd   = bus.vram_rd;
    o_addr = bus.vram_addr;
    o_push = bus.fifo_push_en;
    o_col  = bus.fifo_push_colors;
    o_done = line_done;
    @(posedge clk);
    #1;
  endtask

  // Reference: addresses and pixel words for a whole line, tile by tile.
  task automatic model_line();
    int yy, row, mrow, base, col, maddr, t, daddr;
    logic [7:0]  lo, hi;
    logic [15:0] c;
    exp_addr_q.delete();
    exp_col_q.delete();
    yy   = (int'(ly) + int'(scy)) % 256;
    row  = yy % 8;
    mrow = yy / 8;
    base = map_sel ? 'h1C00 : 'h1800;
    for (int k = 0; k < 21; k++) begin
      col   = (int'(scx) / 8 + k) % 32;
      maddr = base + mrow * 32 + col;
      t     = int'(vram[maddr]);
      if (data_sel) daddr = t * 16 + row * 2;
      else          daddr = (4096 + ((t >= 128) ? t - 256 : t) * 16 + row * 2) % 8192;
      lo = vram[daddr];
      hi = vram[daddr + 1];
      c  = 16'h0000;
      for (int i = 0; i < 8; i++) c = {c[13:0], hi[7-i], lo[7-i]};
      exp_addr_q.push_back(13'(maddr));
      exp_addr_q.push_back(13'(daddr));
      exp_addr_q.push_back(13'(daddr + 1));
      exp_col_q.push_back(c);
    end
  endtask

  // Runs a line (start_line already issued) until line_done or budget.
  task automatic collect_line(input int budget, input bit rnd);
    logic d;
    rd_q.delete();
    col_q.delete();
    done_cnt = 0;
    viol     = 0;
    timeout  = 1'b1;
    for (int c = 0; c < budget; c++) begin
      d = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rnd) bus.fifo_count = 5'($urandom_range(0, 16));
      step(d, 1'b0);
      if (!d && (o_rd || o_push || o_done)) viol++;
      if (o_push && bus.fifo_count > 5'd8) viol++;
      if (o_rd) rd_q.push_back(o_addr);
      if (o_push) col_q.push_back(o_col);
      if (o_done) begin
        done_cnt++;
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    step(1'b1, 1'b0);
    checks++;
    if (o_rd !== 1'b0 || o_push !== 1'b0 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: got rd=%0b push=%0b done=%0b, expected all 0", o_rd, o_push, o_done);
    end
    checks++;
    if (o_addr !== 13'h0000 || o_col !== 16'h0000) begin
      errors++;
      $display("FAIL reset_buses: got addr=%h colors=%h, expected 0000/0000", o_addr, o_col);
    end
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 1'b0);
      checks++;
      if (o_rd !== 1'b0 || o_push !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle: cycle %0d got rd=%0b push=%0b, expected 0/0", c, o_rd, o_push);
      end
    end
    $display("test_reset: done");
  endtask

  task automatic test_basic();
    logic        rd_a [0:7];
    logic [12:0] ad_a [0:7];
    logic        pu_a [0:7];
    logic [15:0] co_a [0:7];
    ly = 8'h00; scx = 8'h00; scy = 8'h00; map_sel = 1'b0; data_sel = 1'b1;
    vram[13'h1800] = 8'h05; vram[13'h0050] = 8'hF0; vram[13'h0051] = 8'hCC;
    bus.fifo_count = 5'd0;
    step(1'b1, 1'b1);
    for (int c = 1; c <= 7; c++) begin
      step(1'b1, 1'b0);
      rd_a[c] = o_rd; ad_a[c] = o_addr; pu_a[c] = o_push; co_a[c] = o_col;
    end
    checks++;
    if (rd_a[1] !== 1'b1 || ad_a[1] !== 13'h1800) begin
      errors++;
      $display("FAIL basic_map_read: got rd=%0b addr=%h, expected rd=1 addr=1800", rd_a[1], ad_a[1]);
    end
    checks++;
    if (rd_a[3] !== 1'b1 || ad_a[3] !== 13'h0050) begin
      errors++;
      $display("FAIL basic_lo_read: got rd=%0b addr=%h, expected rd=1 addr=0050", rd_a[3], ad_a[3]);
    end
    checks++;
    if (rd_a[5] !== 1'b1 || ad_a[5] !== 13'h0051) begin
      errors++;
      $display("FAIL basic_hi_read: got rd=%0b addr=%h, expected rd=1 addr=0051", rd_a[5], ad_a[5]);
    end
    checks++;
    if (rd_a[2] !== 1'b0 || rd_a[4] !== 1'b0 || rd_a[6] !== 1'b0 || pu_a[6] !== 1'b0) begin
      errors++;
      $display("FAIL basic_cap_quiet: got rd=%0b%0b%0b push6=%0b, expected 000 0", rd_a[2], rd_a[4], rd_a[6], pu_a[6]);
    end
    checks++;
    if (pu_a[7] !== 1'b1 || co_a[7] !== 16'hF5A0) begin
      errors++;
      $display("FAIL basic_push: got push=%0b colors=%h, expected push=1 colors=f5a0", pu_a[7], co_a[7]);
    end
    $display("test_basic: push colors=%h", co_a[7]);
  endtask

  task automatic test_signed();
    logic        rd3, rd5;
    logic [12:0] a3, a5;
    ly = 8'h03; scx = 8'h00; scy = 8'h00; map_sel = 1'b0; data_sel = 1'b0;
    vram[13'h1800] = 8'h80;
    bus.fifo_count = 5'd0;
    step(1'b1, 1'b1);
    rd3 = 1'b0; rd5 = 1'b0; a3 = '0; a5 = '0;
    for (int c = 1; c <= 5; c++) begin
      step(1'b1, 1'b0);
      if (c == 3) begin rd3 = o_rd; a3 = o_addr; end
      if (c == 5) begin rd5 = o_rd; a5 = o_addr; end
    end
    checks++;
    if (rd3 !== 1'b1 || a3 !== 13'h0806) begin
      errors++;
      $display("FAIL signed_lo: got rd=%0b addr=%h, expected rd=1 addr=0806", rd3, a3);
    end
    checks++;
    if (rd5 !== 1'b1 || a5 !== 13'h0807) begin
      errors++;
      $display("FAIL signed_hi: got rd=%0b addr=%h, expected rd=1 addr=0807", rd5, a5);
    end
    $display("test_signed: lo=%h hi=%h", a3, a5);
  endtask

  task automatic test_scroll_wrap();
    logic [12:0] a1, a8;
    logic        r1, r8;
    ly = 8'h10; scx = 8'hF8; scy = 8'hF8; map_sel = 1'b1; data_sel = 1'b1;
    bus.fifo_count = 5'd0;
    step(1'b1, 1'b1);
    r1 = 1'b0; r8 = 1'b0; a1 = '0; a8 = '0;
    for (int c = 1; c <= 8; c++) begin
      step(1'b1, 1'b0);
      if (c == 1) begin r1 = o_rd; a1 = o_addr; end
      if (c == 8) begin r8 = o_rd; a8 = o_addr; end
    end
    checks++;
    if (r1 !== 1'b1 || a1 !== 13'h1C3F) begin
      errors++;
      $display("FAIL wrap_first: got rd=%0b addr=%h, expected rd=1 addr=1c3f", r1, a1);
    end
    checks++;
    if (r8 !== 1'b1 || a8 !== 13'h1C20) begin
      errors++;
      $display("FAIL wrap_second: got rd=%0b addr=%h, expected rd=1 addr=1c20", r8, a8);
    end
    $display("test_scroll_wrap: first=%h second=%h", a1, a8);
  endtask

  task automatic test_backpressure();
    int stall_bad;
    ly = 8'h00; scx = 8'h00; scy = 8'h00; map_sel = 1'b0; data_sel = 1'b1;
    bus.fifo_count = 5'd9;
    step(1'b1, 1'b1);
    for (int c = 1; c <= 6; c++) step(1'b1, 1'b0);
    stall_bad = 0;
    for (int c = 7; c <= 9; c++) begin
      step(1'b1, 1'b0);
      if (o_push !== 1'b0 || o_rd !== 1'b0) stall_bad++;
    end
    checks++;
    if (stall_bad != 0) begin
      errors++;
      $display("FAIL bp_stall: got %0d active stall cycles, expected 0", stall_bad);
    end
    bus.fifo_count = 5'd8;
    step(1'b1, 1'b0);
    checks++;
    if (o_push !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got push=%0b, expected 1", o_push);
    end
    step(1'b1, 1'b0);
    checks++;
    if (o_rd !== 1'b1 || o_addr !== 13'h1801) begin
      errors++;
      $display("FAIL bp_next_req: got rd=%0b addr=%h, expected rd=1 addr=1801", o_rd, o_addr);
    end
    $display("test_backpressure: done");
  endtask

  task automatic test_line_end();
    int pushes, dones, last_push, done_at, late_rd;
    ly = 8'h00; scx = 8'h00; scy = 8'h00; map_sel = 1'b0; data_sel = 1'b1;
    bus.fifo_count = 5'd0;
    step(1'b1, 1'b1);
    pushes = 0; dones = 0; last_push = -1; done_at = -1; late_rd = 0;
    for (int c = 1; c <= 200; c++) begin
      step(1'b1, 1'b0);
      if (o_push) begin pushes++; last_push = c; end
      if (o_done) begin dones++; done_at = c; end
      if (done_at > 0 && c > done_at && (o_rd || o_push)) late_rd++;
    end
    checks++;
    if (pushes != 21) begin
      errors++;
      $display("FAIL line_pushes: got %0d, expected 21", pushes);
    end
    checks++;
    if (dones != 1 || done_at != last_push + 1) begin
      errors++;
      $display("FAIL line_done: got %0d pulses at cycle %0d (last push %0d), expected 1 right after", dones, done_at, last_push);
    end
    checks++;
    if (late_rd != 0) begin
      errors++;
      $display("FAIL line_idle: got %0d active cycles after line_done, expected 0", late_rd);
    end
    $display("test_line_end: pushes=%0d done_at=%0d", pushes, done_at);
  endtask

  task automatic test_interrupts();
    int active;
    ly = 8'h00; scx = 8'h00; scy = 8'h00; map_sel = 1'b0; data_sel = 1'b1;
    bus.fifo_count = 5'd0;
    step(1'b1, 1'b1);
    for (int c = 1; c <= 3; c++) step(1'b1, 1'b0);
    // Now in LO_CAP: assert reset mid-cycle.
    dot_en = 1'b1;
    reset  = 1'b0;
    #1;
    checks++;
    if (bus.vram_rd !== 1'b0 || bus.vram_addr !== 13'h0000 || bus.fifo_push_en !== 1'b0 ||
        bus.fifo_push_colors !== 16'h0000 || line_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got rd=%0b addr=%h push=%0b colors=%h done=%0b, expected all 0",
               bus.vram_rd, bus.vram_addr, bus.fifo_push_en, bus.fifo_push_colors, line_done);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    active = 0;
    for (int c = 0; c < 10; c++) begin
      step(1'b1, 1'b0);
      if (o_rd || o_push) active++;
    end
    checks++;
    if (active != 0) begin
      errors++;
      $display("FAIL reset_abandon: got %0d active cycles, expected 0", active);
    end
    scx = 8'h28;
    step(1'b1, 1'b1);
    for (int c = 1; c <= 6; c++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    checks++;
    if (o_push !== 1'b0) begin
      errors++;
      $display("FAIL start_over_push: got push=%0b, expected 0", o_push);
    end
    step(1'b1, 1'b0);
    checks++;
    if (o_rd !== 1'b1 || o_addr !== 13'h1805) begin
      errors++;
      $display("FAIL restart_col: got rd=%0b addr=%h, expected rd=1 addr=1805", o_rd, o_addr);
    end
    $display("test_interrupts: done");
  endtask

  task automatic test_random_lines();
    int amis, cmis;
    for (int n = 0; n < 4; n++) begin
      for (int a = 0; a < 8192; a++) vram[a] = 8'($urandom);
      ly = 8'($urandom); scx = 8'($urandom); scy = 8'($urandom);
      map_sel = 1'($urandom); data_sel = 1'($urandom);
      model_line();
      bus.fifo_count = 5'($urandom_range(0, 16));
      step(1'b1, 1'b1);
      collect_line(4000, 1'b1);
      checks++;
      if (timeout || done_cnt != 1) begin
        errors++;
        $display("FAIL rand_done: line %0d got timeout=%0b done=%0d, expected 0/1", n, timeout, done_cnt);
      end
      checks++;
      if (viol != 0) begin
        errors++;
        $display("FAIL rand_gating: line %0d got %0d violations, expected 0", n, viol);
      end
      amis = 0;
      for (int i = 0; i < rd_q.size() && i < exp_addr_q.size(); i++)
        if (rd_q[i] !== exp_addr_q[i]) amis++;
      checks++;
      if (rd_q.size() != exp_addr_q.size() || amis != 0) begin
        errors++;
        $display("FAIL rand_addrs: line %0d got %0d reads with %0d wrong, expected %0d reads",
                 n, rd_q.size(), amis, exp_addr_q.size());
      end
      cmis = 0;
      for (int i = 0; i < col_q.size() && i < exp_col_q.size(); i++)
        if (col_q[i] !== exp_col_q[i]) cmis++;
      checks++;
      if (col_q.size() != exp_col_q.size() || cmis != 0) begin
        errors++;
        $display("FAIL rand_pixels: line %0d got %0d pushes with %0d wrong, expected %0d pushes",
                 n, col_q.size(), cmis, exp_col_q.size());
      end
      $display("test_random_lines: line %0d ly=%h scx=%h scy=%h map=%0b data=%0b reads=%0d pushes=%0d",
               n, ly, scx, scy, map_sel, data_sel, rd_q.size(), col_q.size());
    end
  endtask

  initial begin
    reset = 1'b0; dot_en = 1'b0; start_line = 1'b0;
    ly = 8'h00; scx = 8'h00; scy = 8'h00; map_sel = 1'b0; data_sel = 1'b1;
    bus.fifo_count = 5'd0;
    for (int a = 0; a < 8192; a++) vram[a] = 8'h00;
    #1;
    test_reset();
    test_basic();
    test_signed();
    test_scroll_wrap();
    test_backpressure();
    test_line_end();
    test_interrupts();
    test_random_lines();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
